// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between IFU (read-only) and LSU.
// Forwards the IDLE winner combinationally, holds the grant until the response, and forces an error response on a stall.
module mem_bus_arbiter #(
   parameter  int TIMEOUT_CYCLES = 256,
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_reqValid,
   input  logic [31:0] ifu_addr,
   output logic        ifu_respValid,
   output logic [31:0] ifu_rdata,
   output logic        ifu_err,
   input  logic        lsu_reqValid,
   input  logic        lsu_lock,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [1:0]  lsu_size,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_respValid,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic        io_reqValid,
   input  logic        io_respValid,
   output logic [31:0] io_addr,
   output logic [31:0] io_wdata,
   input  logic [31:0] io_rdata,
   output logic [1:0]  io_size,
   output logic        io_wen,
   output logic [3:0]  io_wmask
);

   typedef enum logic [1:0] {IDLE, OWN_IFU, OWN_LSU} state_t;

   localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t        state_reg, state_next;
   logic          last_grant_reg, last_grant_next;
   logic [TW-1:0] timer_reg, timer_next;

   logic sel_ifu, sel_lsu, timeout, resp_fire;

   // Current source: the IDLE winner (fresh grant) or the held owner
   always_comb begin
      sel_ifu = 1'b0;
      sel_lsu = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ifu_reqValid && lsu_reqValid) begin
               sel_lsu = ~last_grant_reg;
               sel_ifu = last_grant_reg;
            end else begin
               sel_ifu = ifu_reqValid;
               sel_lsu = lsu_reqValid;
            end
         end
         OWN_IFU: sel_ifu = 1'b1;
         OWN_LSU: sel_lsu = 1'b1;
         default: ;
      endcase
   end

   assign timeout   = (TIMEOUT_CYCLES > 0) && (state_reg != IDLE) &&
                      (timer_reg == TIMER_LAST) && !io_respValid;
   assign resp_fire = (sel_ifu || sel_lsu) && (io_respValid || timeout);

   always_comb begin
      io_addr     = 32'h0;
      io_wdata    = 32'h0;
      io_size     = 2'b00;
      io_wen      = 1'b0;
      io_wmask    = 4'b0000;
      io_reqValid = 1'b0;
      if (sel_ifu) begin
         io_addr = ifu_addr;
         io_size = 2'b10;
      end else if (sel_lsu) begin
         io_addr  = lsu_addr;
         io_wdata = lsu_wdata;
         io_size  = lsu_size;
         io_wen   = lsu_wen;
         io_wmask = lsu_wmask;
      end
      case (state_reg)
         IDLE:    io_reqValid = ifu_reqValid || lsu_reqValid;
         OWN_IFU: io_reqValid = ifu_reqValid && !timeout;
         OWN_LSU: io_reqValid = lsu_reqValid && !timeout;
         default: io_reqValid = 1'b0;
      endcase
   end

   assign ifu_respValid = sel_ifu && resp_fire;
   assign lsu_respValid = sel_lsu && resp_fire;
   assign ifu_err       = sel_ifu && timeout;
   assign lsu_err       = sel_lsu && timeout;
   assign ifu_rdata     = (sel_ifu && timeout) ? 32'h0 : io_rdata;
   assign lsu_rdata     = (sel_lsu && timeout) ? 32'h0 : io_rdata;

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      timer_next      = timer_reg;
      case (state_reg)
         IDLE: begin
            if (sel_ifu || sel_lsu) begin
               timer_next = '0;
               if (io_respValid) begin
                  last_grant_next = sel_lsu;
                  state_next      = (sel_lsu && lsu_lock) ? OWN_LSU : IDLE;
               end else begin
                  state_next = sel_lsu ? OWN_LSU : OWN_IFU;
               end
            end
         end
         OWN_IFU, OWN_LSU: begin
            if (io_respValid) begin
               last_grant_next = sel_lsu;
               timer_next      = '0;
               state_next      = (sel_lsu && lsu_lock) ? OWN_LSU : IDLE;
            end else if (timeout) begin
               last_grant_next = sel_lsu;
               timer_next      = '0;
               state_next      = IDLE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // last_grant resets to LSU so the first tie goes to IFU
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         timer_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         timer_reg      <= timer_next;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter; the bench plays both requesters and the memory.
// The driver predicts each transaction from round-robin/watchdog rules, a negedge monitor checks outputs.
module tb_mem_bus_arbiter;
   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ifu_reqValid = 1'b0;
   logic [31:0] ifu_addr = 32'h0;
   logic        ifu_respValid, ifu_err;
   logic [31:0] ifu_rdata;
   logic        lsu_reqValid = 1'b0, lsu_lock = 1'b0, lsu_wen = 1'b0;
   logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0;
   logic [1:0]  lsu_size = 2'b00;
   logic [3:0]  lsu_wmask = 4'h0;
   logic        lsu_respValid, lsu_err;
   logic [31:0] lsu_rdata;
   logic        io_reqValid, io_wen;
   logic        io_respValid = 1'b0;
   logic [31:0] io_addr, io_wdata;
   logic [31:0] io_rdata = 32'h0;
   logic [1:0]  io_size;
   logic [3:0]  io_wmask;

   always #5 clock = ~clock;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr), .ifu_respValid(ifu_respValid),
      .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
      .lsu_reqValid(lsu_reqValid), .lsu_lock(lsu_lock), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_size(lsu_size), .lsu_wmask(lsu_wmask),
      .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .io_reqValid(io_reqValid), .io_respValid(io_respValid), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_size(io_size), .io_wen(io_wen),
      .io_wmask(io_wmask)
   );

   typedef struct {
      bit          is_lsu;
      logic [31:0] rdata;
      bit          err;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      bit          wen;
      logic [3:0]  wmask;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   bit          exp_io_req = 1'b0;
   bit          ifu_pend = 1'b0, lsu_pend = 1'b0;
   bit          last_lsu = 1'b1;
   bit          locked = 1'b0;
   bit          to_flag;
   logic [31:0] mem [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         chk("io_reqValid", 32'(io_reqValid), 32'(exp_io_req));
         if (io_reqValid) begin
            if (sb.size() == 0) chk("io_req_without_txn", 32'(io_reqValid), 32'h0);
            else begin
               chk("io_addr", io_addr, sb[0].addr);
               chk("io_wdata", io_wdata, sb[0].wdata);
               chk("io_size", 32'(io_size), 32'(sb[0].size));
               chk("io_wen", 32'(io_wen), 32'(sb[0].wen));
               chk("io_wmask", 32'(io_wmask), 32'(sb[0].wmask));
            end
         end
         if (ifu_respValid || lsu_respValid) begin
            if (sb.size() == 0) chk("spurious_resp", {30'd0, ifu_respValid, lsu_respValid}, 32'h0);
            else begin
               mon_e = sb.pop_front();
               chk("resp_who", {30'd0, ifu_respValid, lsu_respValid}, mon_e.is_lsu ? 32'h1 : 32'h2);
               chk("resp_rdata", mon_e.is_lsu ? lsu_rdata : ifu_rdata, mon_e.rdata);
               chk("resp_err", 32'(mon_e.is_lsu ? lsu_err : ifu_err), 32'(mon_e.err));
               $display("txn %s addr=%h rdata=%h err=%0d", mon_e.is_lsu ? "LSU" : "IFU",
                        mon_e.addr, mon_e.rdata, mon_e.err);
            end
         end
         if (!(ifu_respValid && ifu_err)) chk("ifu_rdata_bcast", ifu_rdata, io_rdata);
         if (!(lsu_respValid && lsu_err)) chk("lsu_rdata_bcast", lsu_rdata, io_rdata);
      end
   end

   task automatic new_ifu();
      ifu_addr     = $urandom & 32'hFFFF_FFFC;
      ifu_pend     = 1'b1;
      ifu_reqValid = 1'b1;
   endtask

   task automatic new_lsu();
      lsu_addr     = $urandom;
      lsu_wen      = 1'($urandom);
      lsu_wdata    = $urandom;
      lsu_size     = 2'($urandom_range(0, 2));
      lsu_wmask    = 4'($urandom);
      lsu_pend     = 1'b1;
      lsu_reqValid = 1'b1;
   endtask

   // One granted transaction; d = cycles from grant to the memory's response
   task automatic run_txn(input int d, input bit lock_sel, output bit to);
      bit          w_lsu, own_req;
      int          tcyc, r, idx;
      exp_t        e;
      logic [31:0] resp_data;
      ifu_reqValid = ifu_pend;
      lsu_reqValid = lsu_pend;
      if (locked) w_lsu = 1'b1;
      else if (ifu_pend && lsu_pend) w_lsu = !last_lsu;
      else w_lsu = lsu_pend;
      tcyc = TO - 1 + (locked ? 0 : 1);
      to   = (d > tcyc);
      r    = to ? tcyc : d;
      if (w_lsu) begin
         e.addr = lsu_addr; e.wdata = lsu_wdata; e.size = lsu_size;
         e.wen = lsu_wen; e.wmask = lsu_wmask;
      end else begin
         e.addr = ifu_addr; e.wdata = 32'h0; e.size = 2'b10; e.wen = 1'b0; e.wmask = 4'h0;
      end
      e.is_lsu  = w_lsu;
      idx       = int'(e.addr[5:2]);
      resp_data = e.wen ? $urandom : mem[idx];
      if (e.wen && !to)
         for (int b = 0; b < 4; b++)
            if (e.wmask[b]) mem[idx][8*b +: 8] = e.wdata[8*b +: 8];
      e.err   = to;
      e.rdata = to ? 32'h0 : resp_data;
      sb.push_back(e);
      for (int k = 0; k <= r; k++) begin
         own_req = (k == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (w_lsu) lsu_reqValid = own_req;
         else ifu_reqValid = own_req;
         io_respValid = !to && (k == d);
         io_rdata     = io_respValid ? resp_data : $urandom;
         lsu_lock     = (w_lsu && k == r) ? lock_sel : 1'($urandom);
         exp_io_req   = (to && k == r) ? 1'b0 : own_req;
         @(posedge clock); #1;
      end
      io_respValid = 1'b0;
      if (w_lsu) begin lsu_pend = 1'b0; lsu_reqValid = 1'b0; end
      else begin ifu_pend = 1'b0; ifu_reqValid = 1'b0; end
      last_lsu = w_lsu;
      locked   = w_lsu && lock_sel && !to;
      if (locked) begin
         lsu_addr     = lsu_addr + 32'd4;
         lsu_wdata    = $urandom;
         lsu_pend     = 1'b1;
         lsu_reqValid = 1'b1;
      end
      exp_io_req = ifu_reqValid | lsu_reqValid;
   endtask

   // Cycle with all requests withheld; an io response here must be dropped
   task automatic idle_cycle(input bit late_resp);
      ifu_reqValid = 1'b0;
      lsu_reqValid = 1'b0;
      exp_io_req   = 1'b0;
      io_respValid = late_resp;
      io_rdata     = $urandom;
      lsu_lock     = 1'($urandom);
      @(posedge clock); #1;
      io_respValid = 1'b0;
      ifu_reqValid = ifu_pend;
      lsu_reqValid = lsu_pend;
      exp_io_req   = ifu_pend | lsu_pend;
   endtask

   initial begin
      exp_t e;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[0] = 32'h1234_5678;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_io_addr", io_addr, 32'h0);
      chk("rst_io_wdata", io_wdata, 32'h0);
      chk("rst_ctrl", {19'd0, io_reqValid, io_wen, io_size, io_wmask,
                       ifu_respValid, ifu_err, lsu_respValid, lsu_err}, 32'h0);
      @(posedge clock); #1;

      // IFU alone, same-cycle response
      new_ifu();
      ifu_addr = 32'h8000_0000;
      run_txn(0, 1'b0, to_flag);

      // Misaligned LSU write locked across two halves while IFU waits
      new_ifu();
      new_lsu();
      lsu_addr = 32'h0000_0003; lsu_wen = 1'b1; lsu_wmask = 4'b1000; lsu_size = 2'b10;
      run_txn(2, 1'b1, to_flag);
      run_txn(1, 1'b0, to_flag);
      run_txn(1, 1'b0, to_flag);

      // Both requesting continuously: grants alternate
      for (int n = 0; n < 4; n++) begin
         if (!ifu_pend) new_ifu();
         if (!lsu_pend) new_lsu();
         run_txn(2, 1'b0, to_flag);
      end
      if (ifu_pend) run_txn(1, 1'b0, to_flag);
      if (lsu_pend) run_txn(1, 1'b0, to_flag);

      // LSU read with a stalled memory, then a late response
      new_lsu();
      lsu_wen = 1'b0;
      run_txn(TO + 2, 1'b0, to_flag);
      idle_cycle(1'b1);

      for (int n = 0; n < 300; n++) begin
         if (!ifu_pend && $urandom_range(0, 1) == 1) new_ifu();
         if (!locked && !lsu_pend && $urandom_range(0, 1) == 1) new_lsu();
         if (!ifu_pend && !lsu_pend) begin
            idle_cycle(1'($urandom));
            continue;
         end
         run_txn($urandom_range(0, TO + 2), $urandom_range(0, 3) == 0, to_flag);
         if (to_flag) idle_cycle(1'b1);
      end
      while (ifu_pend || lsu_pend) run_txn(1, 1'b0, to_flag);

      // Reset while IFU owns and waits
      new_ifu();
      e.is_lsu = 1'b0; e.rdata = 32'h0; e.err = 1'b0; e.addr = ifu_addr;
      e.wdata = 32'h0; e.size = 2'b10; e.wen = 1'b0; e.wmask = 4'h0;
      sb.push_back(e);
      exp_io_req = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset        = 1'b0;
      ifu_reqValid = 1'b0;
      ifu_pend     = 1'b0;
      exp_io_req   = 1'b0;
      sb.delete();
      last_lsu = 1'b1;
      locked   = 1'b0;
      @(negedge clock);
      chk("post_rst_io_addr", io_addr, 32'h0);
      chk("post_rst_resp", {28'd0, ifu_respValid, ifu_err, lsu_respValid, lsu_err}, 32'h0);
      @(posedge clock); #1;
      new_ifu();
      new_lsu();
      run_txn(1, 1'b0, to_flag);
      run_txn(1, 1'b0, to_flag);
      @(posedge clock); #1;

      chk("scoreboard_drained", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
